spi_register_bridge: RTL and testbench
======================================

Name: spi_register_bridge

Overview:
- Parametrised successor to the management-board SPI register front end.
- Decodes the byte stream from the SPI slave into read and write transactions on a bank of NUM_CHANNELS registers, each CHANNEL_WIDTH bits.
- Read data is snapshotted per channel so multi-byte sensor values (die serial, voltages, temperatures) stay coherent.
- Sits between the SPI slave and the management controller's sensor/config fabric; single clock domain.

Parameters:
- NUM_CHANNELS, 16: number of register channels; addressable range 0..NUM_CHANNELS-1, NUM_CHANNELS ≤ 256.
- CHANNEL_WIDTH, 64: bits per channel; must be a multiple of 8 (elaboration-time check fails otherwise).
- ERR_WIDTH, 16: width of the saturating error counter.

Ports:
- clk  in  1  system clock (100 MHz domain)
- rst  in  1  asynchronous, active-high reset
- spi_cs_falling  in  1  one-cycle pulse at start of SPI frame
- spi_rx_data_valid  in  1  one-cycle pulse, spi_rx_data valid
- spi_rx_data  in  8  received byte
- spi_tx_data_valid  out  1  one-cycle pulse loading spi_tx_data into slave shifter
- spi_tx_data  out  8  next byte to shift out
- rd_values  in  NUM_CHANNELS*CHANNEL_WIDTH  channel i at bits [i*CHANNEL_WIDTH +: CHANNEL_WIDTH]
- wr_en  out  1  one-cycle write strobe
- wr_addr  out  8  channel written
- wr_data  out  CHANNEL_WIDTH  write value
- err_count  out  ERR_WIDTH  saturating count of protocol errors

Behaviour:
- Reset state:
  - Outputs: spi_tx_data_valid=0, spi_tx_data=0, wr_en=0, wr_addr=0, wr_data=0, err_count=0.
  - Internal: state=IDLE, byte index=0, snapshot=0.
- Derived constant: CHANNEL_BYTES = CHANNEL_WIDTH/8. Data bytes travel LSB first.
- Opcodes (first byte of frame):
  - 0x00 NOP
  - 0x10 READ
  - 0x20 WRITE
  - anything else is BAD.
- States: IDLE, OPCODE, ADDR, READ_DATA, WRITE_DATA, DISCARD.
- spi_cs_falling in any state → OPCODE, byte index=0, partial write buffer cleared.
  - cs_falling has priority over a coincident spi_rx_data_valid; that byte is dropped.
- Transitions on spi_rx_data_valid:
  - IDLE: byte ignored.
  - OPCODE:
    - READ or WRITE → ADDR.
    - NOP → DISCARD.
    - BAD → DISCARD and err_count+1.
  - ADDR:
    - Byte latched as current address.
    - If address ≥ NUM_CHANNELS → DISCARD and err_count+1.
    - READ: snapshot ← channel[addr]; next cycle spi_tx_data_valid=1 with snapshot byte 0; → READ_DATA.
    - WRITE: → WRITE_DATA.
  - READ_DATA:
    - Each rx byte (contents ignored) emits the next snapshot byte exactly 1 cycle later.
    - After byte CHANNEL_BYTES-1 has been emitted, the next rx byte advances the address (wraps NUM_CHANNELS-1→0), re-snapshots, and emits byte 0 of the new channel in the same 1-cycle latency.
  - WRITE_DATA:
    - Each rx byte is stored at byte index.
    - On the CHANNEL_BYTES-th byte, next cycle: wr_en=1, wr_addr=current addr, wr_data=assembled word.
    - Then address auto-increments with the same wrap; byte index=0.
  - DISCARD: all bytes ignored until the next cs_falling.
- Latency: spi_tx_data_valid asserts exactly 1 clk after the triggering rx pulse. No tx pulse in any other case.
- Snapshot rule: rd_values changing mid-channel never mixes old and new bytes within one channel readout.
- Write abort: cs_falling before a channel completes discards the partial word; wr_en never pulses for an incomplete channel.
- err_count saturates at all-ones.
- wr_data/wr_addr hold their last values between strobes.
- Reset mid-frame returns to IDLE. Any byte before the next cs_falling is ignored.

Decomposition:
- Shared package spi_bridge_pkg holds:
  - the opcode enum (bridge_opcode_t: OP_NOP, OP_READ, OP_WRITE)
  - the state enum (bridge_state_t)
  - helper function channel_bytes(width).
- One sub-module, spi_bridge_byte_serdes: holds the CHANNEL_WIDTH shift register used both to serialise snapshots and assemble write words (load, shift-in, byte-out, index). The FSM stays in spi_register_bridge.

Test Plan:
- NUM_CHANNELS=4, CHANNEL_WIDTH=32, channel 2 = 0xDEADBEEF.
  - Stimulus: cs_falling, then 0x10, 0x02, 3 dummy bytes.
  - Response: tx bytes EF, BE, AD, DE, each 1 clk after its triggering rx pulse; err_count=0.
- Auto-increment wrap:
  - Stimulus: READ addr 3, 8 data bytes.
  - Response: channel 3 bytes, then channel 0 bytes.
- Snapshot coherency:
  - Stimulus: change channel 2 to 0x11223344 after the first tx byte.
  - Response: remaining bytes still BE, AD, DE.
- Write:
  - Stimulus: 0x20, 0x01, bytes 78 56 34 12, 0D F0 AD 0B.
  - Response: wr_en pulses twice: (addr1, 0x12345678), then (addr2, 0x0BADF00D).
- Write abort:
  - Stimulus: 0x20, 0x00, two bytes, then cs_falling.
  - Response: no wr_en; the following READ frame behaves normally.
- Errors:
  - Stimulus: opcode 0x55; READ addr 0x07 (NUM_CHANNELS=4); preload err_count near max.
  - Response: err_count increments 1 each, no tx pulses, saturates at 0xFFFF.
- Reset:
  - Stimulus: assert rst mid-READ, asynchronously between clock edges.
  - Response: outputs zero immediately; rx bytes ignored until cs_falling.

Source files
------------

// File: rtl/spi_register_bridge_pkg.sv
// Shared definitions for the SPI register bridge: frame opcodes, decoder
// states and small sizing helpers used by the bridge and its byte serdes.
// No ports.
package spi_bridge_pkg;

  typedef enum logic [7:0] {
    OP_NOP   = 8'h00,
    OP_READ  = 8'h10,
    OP_WRITE = 8'h20
  } bridge_opcode_t;

  typedef enum logic [2:0] {
    IDLE,
    OPCODE,
    ADDR,
    READ_DATA,
    WRITE_DATA,
    DISCARD
  } bridge_state_t;

  function automatic int channel_bytes(input int width);
    return width / 8;
  endfunction

  // Index width for a counter over n items; never below one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_register_bridge_if.sv
// Byte-level handshake between the SPI slave shifter and the register bridge.
// Ports (signals):
//   spi_cs_falling     one-cycle pulse at start of an SPI frame
//   spi_rx_data_valid  one-cycle pulse, spi_rx_data valid
//   spi_rx_data        received byte
//   spi_tx_data_valid  one-cycle pulse loading spi_tx_data into the shifter
//   spi_tx_data        next byte to shift out
// master = SPI slave shifter side, slave = register bridge side.
interface spi_register_bridge_if;
  logic       spi_cs_falling;
  logic       spi_rx_data_valid;
  logic [7:0] spi_rx_data;
  logic       spi_tx_data_valid;
  logic [7:0] spi_tx_data;

  modport master (
    output spi_cs_falling, spi_rx_data_valid, spi_rx_data,
    input  spi_tx_data_valid, spi_tx_data
  );

  modport slave (
    input  spi_cs_falling, spi_rx_data_valid, spi_rx_data,
    output spi_tx_data_valid, spi_tx_data
  );
endinterface

// File: rtl/spi_register_bridge_byte_serdes.sv
// Channel-wide byte buffer shared by read serialisation and write assembly.
// Ports:
//   clk, rst     clock, async active-high reset
//   clear        zero the buffer and byte index
//   load         capture load_word (snapshot); index points at byte 1
//   put          store put_byte at the current index, advance index
//   step         advance index (a byte was emitted)
//   cur_byte     byte at the current index
//   merged_word  buffer with put_byte inserted at the current index
//   idx_zero     index is 0 (whole channel consumed after a wrap)
//   idx_last     index is the final byte of the channel
module spi_bridge_byte_serdes
  import spi_bridge_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_word,
  input  logic             put,
  input  logic [7:0]       put_byte,
  input  logic             step,
  output logic [7:0]       cur_byte,
  output logic [WIDTH-1:0] merged_word,
  output logic             idx_zero,
  output logic             idx_last
);

  localparam int NB = channel_bytes(WIDTH);
  localparam int IW = idx_width(NB);

  logic [WIDTH-1:0] word_q;
  logic [IW-1:0]    idx_q;
  logic [IW-1:0]    idx_inc;

  assign idx_last = (idx_q == IW'(NB - 1));
  assign idx_zero = (idx_q == '0);
  assign idx_inc  = idx_last ? '0 : idx_q + 1'b1;
  assign cur_byte = word_q[int'(idx_q)*8 +: 8];

  always_comb begin
    merged_word = word_q;
    merged_word[int'(idx_q)*8 +: 8] = put_byte;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
      idx_q  <= '0;
    end else if (clear) begin
      word_q <= '0;
      idx_q  <= '0;
    end else if (load) begin
      // Byte 0 leaves straight from load_word, so the next one to emit is 1.
      word_q <= load_word;
      idx_q  <= (NB > 1) ? IW'(1) : '0;
    end else if (put) begin
      word_q <= merged_word;
      idx_q  <= idx_inc;
    end else if (step) begin
      idx_q  <= idx_inc;
    end
  end

endmodule

// File: rtl/spi_register_bridge.sv
// Decodes SPI byte frames (opcode, address, data) into register reads and
// writes over NUM_CHANNELS channels of CHANNEL_WIDTH bits, LSB byte first.
// Reads are served from a per-channel snapshot so a channel never mixes old
// and new bytes; both reads and writes auto-increment the address with wrap.
// Ports:
//   clk, rst    clock, async active-high reset
//   spi         byte handshake with the SPI slave (slave modport)
//   rd_values   channel i at [i*CHANNEL_WIDTH +: CHANNEL_WIDTH]
//   wr_en       one-cycle write strobe
//   wr_addr     channel written (held between strobes)
//   wr_data     write value (held between strobes)
//   err_count   saturating count of protocol errors
module spi_register_bridge
  import spi_bridge_pkg::*;
#(
  parameter int NUM_CHANNELS  = 16,
  parameter int CHANNEL_WIDTH = 64,
  parameter int ERR_WIDTH     = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  spi_register_bridge_if.slave                spi,
  input  logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0] rd_values,
  output logic                                wr_en,
  output logic [7:0]                          wr_addr,
  output logic [CHANNEL_WIDTH-1:0]            wr_data,
  output logic [ERR_WIDTH-1:0]                err_count
);

  localparam int AW = idx_width(NUM_CHANNELS);

  if ((CHANNEL_WIDTH % 8) != 0 || CHANNEL_WIDTH < 8) begin : g_bad_width
    $error("spi_register_bridge: CHANNEL_WIDTH must be a positive multiple of 8");
  end
  if (NUM_CHANNELS < 1 || NUM_CHANNELS > 256) begin : g_bad_channels
    $error("spi_register_bridge: NUM_CHANNELS must be in 1..256");
  end

  bridge_state_t state_q, state_n;
  logic [7:0]               addr_q, addr_n, addr_inc, sel_addr;
  logic                     is_wr_q, is_wr_n;
  logic                     tx_valid_q, tx_valid_n;
  logic [7:0]               tx_data_q, tx_data_n;
  logic                     wr_en_n;
  logic [7:0]               wr_addr_n;
  logic [CHANNEL_WIDTH-1:0] wr_data_n;
  logic [ERR_WIDTH-1:0]     err_n;
  logic                     err_inc;
  logic                     addr_bad;

  logic                     sd_clear, sd_load, sd_put, sd_step;
  logic [7:0]               sd_cur_byte;
  logic [CHANNEL_WIDTH-1:0] sd_merged;
  logic                     sd_idx_zero, sd_idx_last;

  logic [CHANNEL_WIDTH-1:0] chan [NUM_CHANNELS];
  logic [CHANNEL_WIDTH-1:0] sel_word;

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
    assign chan[i] = rd_values[i*CHANNEL_WIDTH +: CHANNEL_WIDTH];
  end

  assign addr_inc = (addr_q == 8'(NUM_CHANNELS - 1)) ? 8'd0 : addr_q + 8'd1;
  assign addr_bad = ({1'b0, spi.spi_rx_data} >= 9'(NUM_CHANNELS));
  // The only channel fetches are the first one (address byte) and the wrap.
  assign sel_addr = (state_q == ADDR) ? spi.spi_rx_data : addr_inc;
  assign sel_word = chan[sel_addr[AW-1:0]];

  spi_bridge_byte_serdes #(.WIDTH(CHANNEL_WIDTH)) u_serdes (
    .clk         (clk),
    .rst         (rst),
    .clear       (sd_clear),
    .load        (sd_load),
    .load_word   (sel_word),
    .put         (sd_put),
    .put_byte    (spi.spi_rx_data),
    .step        (sd_step),
    .cur_byte    (sd_cur_byte),
    .merged_word (sd_merged),
    .idx_zero    (sd_idx_zero),
    .idx_last    (sd_idx_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      is_wr_q    <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      err_count  <= '0;
    end else begin
      state_q    <= state_n;
      addr_q     <= addr_n;
      is_wr_q    <= is_wr_n;
      tx_valid_q <= tx_valid_n;
      tx_data_q  <= tx_data_n;
      wr_en      <= wr_en_n;
      wr_addr    <= wr_addr_n;
      wr_data    <= wr_data_n;
      err_count  <= err_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    addr_n     = addr_q;
    is_wr_n    = is_wr_q;
    tx_valid_n = 1'b0;
    tx_data_n  = tx_data_q;
    wr_en_n    = 1'b0;
    wr_addr_n  = wr_addr;
    wr_data_n  = wr_data;
    err_inc    = 1'b0;
    sd_clear   = 1'b0;
    sd_load    = 1'b0;
    sd_put     = 1'b0;
    sd_step    = 1'b0;

    if (spi.spi_cs_falling) begin
      // Frame start wins; a coincident byte is dropped.
      state_n  = OPCODE;
      sd_clear = 1'b1;
    end else if (spi.spi_rx_data_valid) begin
      case (state_q)
        OPCODE: begin
          case (spi.spi_rx_data)
            OP_READ:  begin is_wr_n = 1'b0; state_n = ADDR; end
            OP_WRITE: begin is_wr_n = 1'b1; state_n = ADDR; end
            OP_NOP:   state_n = DISCARD;
            default: begin
              state_n = DISCARD;
              err_inc = 1'b1;
            end
          endcase
        end
        ADDR: begin
          addr_n = spi.spi_rx_data;
          if (addr_bad) begin
            state_n = DISCARD;
            err_inc = 1'b1;
          end else if (is_wr_q) begin
            state_n  = WRITE_DATA;
            sd_clear = 1'b1;
          end else begin
            state_n    = READ_DATA;
            sd_load    = 1'b1;
            tx_valid_n = 1'b1;
            tx_data_n  = sel_word[7:0];
          end
        end
        READ_DATA: begin
          tx_valid_n = 1'b1;
          if (sd_idx_zero) begin
            // Previous channel fully emitted: move on and re-snapshot.
            addr_n    = addr_inc;
            sd_load   = 1'b1;
            tx_data_n = sel_word[7:0];
          end else begin
            tx_data_n = sd_cur_byte;
            sd_step   = 1'b1;
          end
        end
        WRITE_DATA: begin
          sd_put = 1'b1;
          if (sd_idx_last) begin
            wr_en_n   = 1'b1;
            wr_addr_n = addr_q;
            wr_data_n = sd_merged;
            addr_n    = addr_inc;
          end
        end
        default: ;  // IDLE and DISCARD ignore bytes
      endcase
    end

    err_n = (err_inc && (err_count != '1)) ? err_count + 1'b1 : err_count;
  end

  assign spi.spi_tx_data_valid = tx_valid_q;
  assign spi.spi_tx_data       = tx_data_q;

endmodule

// File: tb/tb_spi_register_bridge.sv
module tb_spi_register_bridge;

  localparam int NC = 4;
  localparam int CW = 32;
  localparam int EW = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NC*CW-1:0]  rd_values;
  logic              wr_en;
  logic [7:0]        wr_addr;
  logic [CW-1:0]     wr_data;
  logic [EW-1:0]     err_count;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;

  always #5 clk = ~clk;

  spi_register_bridge_if spi ();

  spi_register_bridge #(
    .NUM_CHANNELS  (NC),
    .CHANNEL_WIDTH (CW),
    .ERR_WIDTH     (EW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .spi       (spi.slave),
    .rd_values (rd_values),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .err_count (err_count)
  );

  always @(posedge clk) if (wr_en === 1'b1) wr_cnt <= wr_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cs_pulse(input logic with_rx, input logic [7:0] b);
    @(negedge clk);
    spi.spi_cs_falling    = 1'b1;
    spi.spi_rx_data_valid = with_rx;
    spi.spi_rx_data       = b;
    @(negedge clk);
    spi.spi_cs_falling    = 1'b0;
    spi.spi_rx_data_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    spi.spi_rx_data_valid = 1'b1;
    spi.spi_rx_data       = b;
    @(negedge clk);
    spi.spi_rx_data_valid = 1'b0;
  endtask

  task automatic rx_tx(input string tag, input logic [7:0] b, input logic [7:0] exp);
    send(b);
    chk({tag, "_valid"}, 64'(spi.spi_tx_data_valid), 64'd1);
    chk({tag, "_data"}, 64'(spi.spi_tx_data), 64'(exp));
  endtask

  task automatic rx_quiet(input string tag, input logic [7:0] b);
    send(b);
    chk({tag, "_notx"}, 64'(spi.spi_tx_data_valid), 64'd0);
  endtask

  initial begin
    spi.spi_cs_falling    = 1'b0;
    spi.spi_rx_data_valid = 1'b0;
    spi.spi_rx_data       = 8'h00;
    rd_values = {32'hCAFEF00D, 32'hDEADBEEF, 32'h0BADCAFE, 32'h76543210};

    repeat (2) @(negedge clk);
    chk("rst_tx_valid", 64'(spi.spi_tx_data_valid), 64'd0);
    chk("rst_tx_data", 64'(spi.spi_tx_data), 64'd0);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    chk("rst_err", 64'(err_count), 64'd0);
    rst = 1'b0;

    // Bytes before any frame start are ignored.
    rx_quiet("idle0", 8'h10);
    rx_quiet("idle1", 8'h02);

    // Basic read of channel 2.
    cs_pulse(1'b0, 8'h00);
    rx_quiet("rd_op", 8'h10);
    rx_tx("rd_b0", 8'h02, 8'hEF);
    rx_tx("rd_b1", 8'h00, 8'hBE);
    rx_tx("rd_b2", 8'h00, 8'hAD);
    rx_tx("rd_b3", 8'h00, 8'hDE);
    @(negedge clk);
    chk("rd_tx_drop", 64'(spi.spi_tx_data_valid), 64'd0);
    chk("rd_err", 64'(err_count), 64'd0);

    // Read from the last channel wraps to channel 0, then channel 1.
    cs_pulse(1'b0, 8'h00);
    rx_quiet("wrap_op", 8'h10);
    rx_tx("wrap_c3b0", 8'h03, 8'h0D);
    rx_tx("wrap_c3b1", 8'h00, 8'hF0);
    rx_tx("wrap_c3b2", 8'h00, 8'hFE);
    rx_tx("wrap_c3b3", 8'h00, 8'hCA);
    rx_tx("wrap_c0b0", 8'h00, 8'h10);
    rx_tx("wrap_c0b1", 8'h00, 8'h32);
    rx_tx("wrap_c0b2", 8'h00, 8'h54);
    rx_tx("wrap_c0b3", 8'h00, 8'h76);
    rx_tx("wrap_c1b0", 8'h00, 8'hFE);

    // Snapshot coherency: channel 2 changes after its first byte goes out.
    cs_pulse(1'b0, 8'h00);
    rx_quiet("snap_op", 8'h10);
    rx_tx("snap_b0", 8'h02, 8'hEF);
    rd_values[2*CW +: CW] = 32'h11223344;
    rx_tx("snap_b1", 8'h00, 8'hBE);
    rx_tx("snap_b2", 8'h00, 8'hAD);
    rx_tx("snap_b3", 8'h00, 8'hDE);
    rx_tx("snap_c3b0", 8'h00, 8'h0D);

    // Two-channel write starting at channel 1.
    cs_pulse(1'b0, 8'h00);
    rx_quiet("wr_op", 8'h20);
    rx_quiet("wr_addr", 8'h01);
    rx_quiet("wr_a0", 8'h78);
    chk("wr_partial", 64'(wr_en), 64'd0);
    rx_quiet("wr_a1", 8'h56);
    rx_quiet("wr_a2", 8'h34);
    rx_quiet("wr_a3", 8'h12);
    chk("wr1_en", 64'(wr_en), 64'd1);
    chk("wr1_addr", 64'(wr_addr), 64'd1);
    chk("wr1_data", 64'(wr_data), 64'h12345678);
    rx_quiet("wr_b0", 8'h0D);
    chk("wr1_single", 64'(wr_en), 64'd0);
    rx_quiet("wr_b1", 8'hF0);
    rx_quiet("wr_b2", 8'hAD);
    rx_quiet("wr_b3", 8'h0B);
    chk("wr2_en", 64'(wr_en), 64'd1);
    chk("wr2_addr", 64'(wr_addr), 64'd2);
    chk("wr2_data", 64'(wr_data), 64'h0BADF00D);
    repeat (3) @(negedge clk);
    chk("wr_count", 64'(wr_cnt), 64'd2);
    chk("wr_hold_addr", 64'(wr_addr), 64'd2);
    chk("wr_hold_data", 64'(wr_data), 64'h0BADF00D);

    // Abort a write mid-channel; the new frame start also carries a byte
    // that must be dropped rather than parsed as an opcode.
    cs_pulse(1'b0, 8'h00);
    rx_quiet("ab_op", 8'h20);
    rx_quiet("ab_addr", 8'h00);
    rx_quiet("ab_d0", 8'hAA);
    rx_quiet("ab_d1", 8'hBB);
    cs_pulse(1'b1, 8'h55);
    rx_quiet("ab_rd_op", 8'h10);
    rx_tx("ab_rd_b0", 8'h01, 8'hFE);
    rx_tx("ab_rd_b1", 8'h00, 8'hCA);
    repeat (2) @(negedge clk);
    chk("ab_wr_count", 64'(wr_cnt), 64'd2);
    chk("ab_err", 64'(err_count), 64'd0);
    chk("ab_hold_data", 64'(wr_data), 64'h0BADF00D);

    // Protocol errors.
    cs_pulse(1'b0, 8'h00);
    rx_quiet("bad_op", 8'h55);
    chk("bad_op_err", 64'(err_count), 64'd1);
    rx_quiet("bad_op_tail", 8'h02);
    cs_pulse(1'b0, 8'h00);
    rx_quiet("bad_addr_op", 8'h10);
    rx_quiet("bad_addr", 8'h07);
    chk("bad_addr_err", 64'(err_count), 64'd2);
    rx_quiet("bad_addr_tail0", 8'h00);
    rx_quiet("bad_addr_tail1", 8'h00);
    cs_pulse(1'b0, 8'h00);
    rx_quiet("nop_op", 8'h00);
    rx_quiet("nop_tail", 8'h10);
    chk("nop_err", 64'(err_count), 64'd2);
    for (int i = 0; i < 252; i++) begin
      cs_pulse(1'b0, 8'h00);
      send(8'hA5);
    end
    chk("err_near_max", 64'(err_count), 64'hFE);
    cs_pulse(1'b0, 8'h00);
    send(8'hFF);
    chk("err_max", 64'(err_count), 64'hFF);
    for (int i = 0; i < 5; i++) begin
      cs_pulse(1'b0, 8'h00);
      send(8'h33);
    end
    chk("err_saturated", 64'(err_count), 64'hFF);

    // Asynchronous reset in the middle of a read, between clock edges.
    cs_pulse(1'b0, 8'h00);
    rx_quiet("rr_op", 8'h10);
    rx_tx("rr_b0", 8'h02, 8'h44);
    #2 rst = 1'b1;
    #1;
    chk("arst_tx_valid", 64'(spi.spi_tx_data_valid), 64'd0);
    chk("arst_tx_data", 64'(spi.spi_tx_data), 64'd0);
    chk("arst_err", 64'(err_count), 64'd0);
    chk("arst_wr_addr", 64'(wr_addr), 64'd0);
    chk("arst_wr_data", 64'(wr_data), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    rx_quiet("post_rst0", 8'h10);
    rx_quiet("post_rst1", 8'h02);
    rx_quiet("post_rst2", 8'h00);
    cs_pulse(1'b0, 8'h00);
    rx_quiet("post_rd_op", 8'h10);
    rx_tx("post_rd_b0", 8'h02, 8'h44);
    rx_tx("post_rd_b1", 8'h00, 8'h33);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
